// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the write-request record and the requester index constants.
package regfile_write_arbiter_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] reg_idx;
      logic [DATA_W_DEF-1:0] data;
   } wr_req_t;

   localparam logic REQ_EX  = 1'b0;
   localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/regfile_wr_buffer.sv
// One-entry write-request holding buffer with a valid/ready handshake.
// Writes to register 0 are acknowledged on the handshake but never stored.
module regfile_wr_buffer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_reg,
   input  logic [DATA_W-1:0] in_data,
   input  logic              drain,
   output logic              ready,
   output logic              load,
   output logic              full,
   output logic [ADDR_W-1:0] buf_reg,
   output logic [DATA_W-1:0] buf_data
);

   logic              full_d, full_q;
   logic [ADDR_W-1:0] reg_d, reg_q;
   logic [DATA_W-1:0] data_d, data_q;

   // Ready follows from state only so a drained slot can be refilled on the same edge.
   assign ready = rst_n & (~full_q | drain);
   assign load  = in_valid & ready & (in_reg != {ADDR_W{1'b0}});

   // Next buffer contents: a load wins over a drain of the same slot.
   always_comb begin
      full_d = full_q;
      reg_d  = reg_q;
      data_d = data_q;
      if (load) begin
         full_d = 1'b1;
         reg_d  = in_reg;
         data_d = in_data;
      end else if (drain) begin
         full_d = 1'b0;
      end else begin
         full_d = full_q;
      end
   end

   // Buffer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         reg_q  <= {ADDR_W{1'b0}};
         data_q <= {DATA_W{1'b0}};
      end else begin
         full_q <= full_d;
         reg_q  <= reg_d;
         data_q <= data_d;
      end
   end

   assign full     = full_q;
   assign buf_reg  = reg_q;
   assign buf_data = data_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write-port arbiter (oldest first, round-robin tie-break).
// Optional conflict statistics port and counter are built when REGWR_ARB_STATS_EN is defined.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Req0Valid,
   output logic                   Req0Ready,
   input  logic [ADDR_W-1:0]      Req0Reg,
   input  logic [DATA_W-1:0]      Req0Data,
   input  logic                   Req1Valid,
   output logic                   Req1Ready,
   input  logic [ADDR_W-1:0]      Req1Reg,
   input  logic [DATA_W-1:0]      Req1Data,
`ifdef REGWR_ARB_STATS_EN
   input  logic                   ConflictClear,
   output logic [15:0]            ConflictCount,
`endif
   output logic                   RegWrite,
   output logic [ADDR_W-1:0]      WriteRegister,
   output logic [DATA_W-1:0]      WriteData,
   output logic [(1<<ADDR_W)-1:0] PendingMask
);

   localparam int NREG = 1 << ADDR_W;

   logic              full0_s, full1_s, load0_s, load1_s, drain0_s, drain1_s;
   logic [ADDR_W-1:0] buf_reg0_s, buf_reg1_s;
   logic [DATA_W-1:0] buf_data0_s, buf_data1_s;
   logic              grant_valid_s, grant_idx_s;
   logic              ptr_d, ptr_q, age_d, age_q, tie_d, tie_q;
   logic              next_full0_s, next_full1_s;
   logic              regwrite_d, regwrite_q;
   logic [ADDR_W-1:0] wr_reg_d, wr_reg_q;
   logic [DATA_W-1:0] wr_data_d, wr_data_q;
   logic [NREG-1:0]   pending_s;

   regfile_wr_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_ex (
      .clk      (clk),
      .rst_n    (reset),
      .in_valid (Req0Valid),
      .in_reg   (Req0Reg),
      .in_data  (Req0Data),
      .drain    (drain0_s),
      .ready    (Req0Ready),
      .load     (load0_s),
      .full     (full0_s),
      .buf_reg  (buf_reg0_s),
      .buf_data (buf_data0_s)
   );

   regfile_wr_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf_mem (
      .clk      (clk),
      .rst_n    (reset),
      .in_valid (Req1Valid),
      .in_reg   (Req1Reg),
      .in_data  (Req1Data),
      .drain    (drain1_s),
      .ready    (Req1Ready),
      .load     (load1_s),
      .full     (full1_s),
      .buf_reg  (buf_reg1_s),
      .buf_data (buf_data1_s)
   );

   // Grant selection; the pointer only moves when it actually broke a tie.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = REQ_EX;
      ptr_d         = ptr_q;
      case ({full1_s, full0_s})
         2'b01: begin
            grant_valid_s = 1'b1;
            grant_idx_s   = REQ_EX;
         end
         2'b10: begin
            grant_valid_s = 1'b1;
            grant_idx_s   = REQ_MEM;
         end
         2'b11: begin
            grant_valid_s = 1'b1;
            if (tie_q) begin
               grant_idx_s = ptr_q;
               ptr_d       = ~ptr_q;
            end else begin
               grant_idx_s = age_q;
            end
         end
         default: begin
            grant_valid_s = 1'b0;
            grant_idx_s   = REQ_EX;
         end
      endcase
      drain0_s = grant_valid_s & (grant_idx_s == REQ_EX);
      drain1_s = grant_valid_s & (grant_idx_s == REQ_MEM);
   end

   // Age tracking: age_q names the older buffer, tie_q marks a same-edge double load.
   always_comb begin
      next_full0_s = load0_s | (full0_s & ~drain0_s);
      next_full1_s = load1_s | (full1_s & ~drain1_s);
      age_d        = age_q;
      tie_d        = tie_q;
      if (next_full0_s && next_full1_s) begin
         case ({load1_s, load0_s})
            2'b11: tie_d = 1'b1;
            2'b01: begin
               tie_d = 1'b0;
               age_d = REQ_MEM;
            end
            2'b10: begin
               tie_d = 1'b0;
               age_d = REQ_EX;
            end
            default: begin
               tie_d = tie_q;
               age_d = age_q;
            end
         endcase
      end else begin
         tie_d = 1'b0;
      end
   end

   // Write stage: index and data hold when nothing is granted.
   always_comb begin
      regwrite_d = grant_valid_s;
      wr_reg_d   = wr_reg_q;
      wr_data_d  = wr_data_q;
      if (grant_valid_s) begin
         wr_reg_d  = (grant_idx_s == REQ_MEM) ? buf_reg1_s  : buf_reg0_s;
         wr_data_d = (grant_idx_s == REQ_MEM) ? buf_data1_s : buf_data0_s;
      end else begin
         wr_reg_d  = wr_reg_q;
         wr_data_d = wr_data_q;
      end
   end

   // Arbiter and write-stage state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q      <= 1'b0;
         age_q      <= 1'b0;
         tie_q      <= 1'b0;
         regwrite_q <= 1'b0;
         wr_reg_q   <= {ADDR_W{1'b0}};
         wr_data_q  <= {DATA_W{1'b0}};
      end else begin
         ptr_q      <= ptr_d;
         age_q      <= age_d;
         tie_q      <= tie_d;
         regwrite_q <= regwrite_d;
         wr_reg_q   <= wr_reg_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Outstanding-write decode; register 0 is never reported.
   always_comb begin
      pending_s = (full0_s ? ({{(NREG-1){1'b0}}, 1'b1} << buf_reg0_s) : {NREG{1'b0}})
                | (full1_s ? ({{(NREG-1){1'b0}}, 1'b1} << buf_reg1_s) : {NREG{1'b0}})
                | (regwrite_q ? ({{(NREG-1){1'b0}}, 1'b1} << wr_reg_q) : {NREG{1'b0}});
      pending_s = pending_s & {{(NREG-1){1'b1}}, 1'b0};
   end

   assign RegWrite      = regwrite_q;
   assign WriteRegister = wr_reg_q;
   assign WriteData     = wr_data_q;
   assign PendingMask   = pending_s;

`ifdef REGWR_ARB_STATS_EN
   logic [15:0] conflict_d, conflict_q;

   // Saturating count of cycles in which one requester is kept waiting.
   always_comb begin
      conflict_d = conflict_q;
      if (ConflictClear) begin
         conflict_d = 16'd0;
      end else if (full0_s && full1_s && (conflict_q != 16'hFFFF)) begin
         conflict_d = conflict_q + 16'd1;
      end else begin
         conflict_d = conflict_q;
      end
   end

   // Conflict counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         conflict_q <= 16'd0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign ConflictCount = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: scoreboard of expected writes
// popped by a write-port monitor, plus per-scenario inline checks.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk, reset;
   logic          Req0Valid, Req0Ready, Req1Valid, Req1Ready;
   logic [AW-1:0] Req0Reg, Req1Reg, WriteRegister;
   logic [DW-1:0] Req0Data, Req1Data, WriteData;
   logic          RegWrite;
   logic [31:0]   PendingMask;
`ifdef REGWR_ARB_STATS_EN
   logic          ConflictClear;
   logic [15:0]   ConflictCount;
`endif

   int checks = 0;
   int errors = 0;
   wr_req_t exp_q[$];
   logic [DW-1:0] model_rf [32];

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk           (clk),
      .reset         (reset),
      .Req0Valid     (Req0Valid),
      .Req0Ready     (Req0Ready),
      .Req0Reg       (Req0Reg),
      .Req0Data      (Req0Data),
      .Req1Valid     (Req1Valid),
      .Req1Ready     (Req1Ready),
      .Req1Reg       (Req1Reg),
      .Req1Data      (Req1Data),
`ifdef REGWR_ARB_STATS_EN
      .ConflictClear (ConflictClear),
      .ConflictCount (ConflictCount),
`endif
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .PendingMask   (PendingMask)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Write-port monitor: every RegWrite cycle must match the oldest expected write.
   always @(negedge clk) begin
      if (RegWrite === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got reg %0d data %h, expected no write", WriteRegister, WriteData);
         end else begin
            wr_req_t e;
            e = exp_q.pop_front();
            if (WriteRegister !== e.reg_idx || WriteData !== e.data) begin
               errors++;
               $display("FAIL write_order: got reg %0d data %h, expected reg %0d data %h",
                        WriteRegister, WriteData, e.reg_idx, e.data);
            end
         end
         model_rf[WriteRegister] = WriteData;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Req0Valid = 1'b0;
      Req1Valid = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
      wr_req_t e;
      e.reg_idx = r;
      e.data    = d;
      exp_q.push_back(e);
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drained: got %0d writes outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      Req0Reg = 5'd3; Req0Data = 32'h0; Req1Reg = 5'd0; Req1Data = 32'h0;
`ifdef REGWR_ARB_STATS_EN
      ConflictClear = 1'b0;
`endif
      #2;
      checks++;
      if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'h0 || PendingMask !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got we %b reg %0d data %h mask %h, expected 0 0 0 0",
                  RegWrite, WriteRegister, WriteData, PendingMask);
      end
      checks++;
      if (Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: got %b%b, expected 00", Req0Ready, Req1Ready);
      end
`ifdef REGWR_ARB_STATS_EN
      checks++;
      if (ConflictCount !== 16'd0) begin
         errors++;
         $display("FAIL reset_conflict: got %0d, expected 0", ConflictCount);
      end
`endif
      Req0Valid = 1'b1;
      step();
      step();
      checks++;
      if (PendingMask !== 32'h0 || RegWrite !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: got mask %h we %b, expected 0 0", PendingMask, RegWrite);
      end
      idle();
      #2 reset = 1'b1;
      step();
      checks++;
      if (Req0Ready !== 1'b1 || Req1Ready !== 1'b1) begin
         errors++;
         $display("FAIL release_ready: got %b%b, expected 11", Req0Ready, Req1Ready);
      end
   endtask

   task automatic test_single();
      Req0Valid = 1'b1; Req0Reg = 5'd5; Req0Data = 32'hDEADBEEF;
      push(5'd5, 32'hDEADBEEF);
      step();
      idle();
      checks++;
      if (PendingMask !== 32'h0000_0020 || RegWrite !== 1'b0) begin
         errors++;
         $display("FAIL single_accept: got mask %h we %b, expected 00000020 0", PendingMask, RegWrite);
      end
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF || PendingMask !== 32'h0000_0020) begin
         errors++;
         $display("FAIL single_stage: got we %b reg %0d data %h mask %h, expected 1 5 deadbeef 00000020",
                  RegWrite, WriteRegister, WriteData, PendingMask);
      end
      step();
      checks++;
      if (RegWrite !== 1'b0 || PendingMask !== 32'h0 || WriteRegister !== 5'd5 || WriteData !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_done: got we %b mask %h reg %0d data %h, expected 0 0 5 deadbeef",
                  RegWrite, PendingMask, WriteRegister, WriteData);
      end
      check_drained("single");
   endtask

   task automatic test_reg0();
      Req1Valid = 1'b1; Req1Reg = 5'd0; Req1Data = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (Req1Ready !== 1'b1) begin
            errors++;
            $display("FAIL reg0_ready: got %b, expected 1 (cycle %0d)", Req1Ready, i);
         end
         step();
         checks++;
         if (RegWrite !== 1'b0 || PendingMask !== 32'h0) begin
            errors++;
            $display("FAIL reg0_discard: got we %b mask %h, expected 0 0", RegWrite, PendingMask);
         end
      end
      idle();
      step();
   endtask

   task automatic test_tie();
      Req0Valid = 1'b1; Req0Reg = 5'd3; Req0Data = 32'hA;
      Req1Valid = 1'b1; Req1Reg = 5'd4; Req1Data = 32'hB;
      push(5'd3, 32'hA);
      push(5'd4, 32'hB);
      step();
      idle();
      checks++;
      if (PendingMask !== 32'h0000_0018) begin
         errors++;
         $display("FAIL tie_mask: got %h, expected 00000018", PendingMask);
      end
      step();
      step();
      step();
      // Pointer has moved to requester 1, so the second tie starts with it.
      Req0Valid = 1'b1; Req0Reg = 5'd8; Req0Data = 32'hC;
      Req1Valid = 1'b1; Req1Reg = 5'd9; Req1Data = 32'hD;
      push(5'd9, 32'hD);
      push(5'd8, 32'hC);
      step();
      idle();
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'd9) begin
         errors++;
         $display("FAIL tie2_first: got we %b reg %0d, expected 1 9", RegWrite, WriteRegister);
      end
      step();
      step();
      check_drained("tie");
   endtask

   task automatic test_oldest();
      Req1Valid = 1'b1; Req1Reg = 5'd7; Req1Data = 32'h1;
      push(5'd7, 32'h1);
      step();
      Req1Valid = 1'b0;
      Req0Valid = 1'b1; Req0Reg = 5'd7; Req0Data = 32'h2;
      push(5'd7, 32'h2);
      step();
      idle();
      step();
      step();
      step();
      checks++;
      if (model_rf[7] !== 32'h2) begin
         errors++;
         $display("FAIL oldest_final: got r7 %h, expected 00000002", model_rf[7]);
      end
      // Refilled buffer 0 is younger than the still-waiting buffer 1.
      Req0Valid = 1'b1; Req0Reg = 5'd10; Req0Data = 32'h10;
      Req1Valid = 1'b1; Req1Reg = 5'd11; Req1Data = 32'h11;
      push(5'd10, 32'h10);
      step();
      Req1Valid = 1'b0;
      Req0Reg = 5'd12; Req0Data = 32'h12;
      push(5'd11, 32'h11);
      push(5'd12, 32'h12);
      checks++;
      if (Req0Ready !== 1'b1) begin
         errors++;
         $display("FAIL refill_ready: got %b, expected 1", Req0Ready);
      end
      step();
      idle();
      checks++;
      if (PendingMask !== 32'h0000_1C00) begin
         errors++;
         $display("FAIL age_mask: got %h, expected 00001c00", PendingMask);
      end
      step();
      step();
      step();
      check_drained("oldest");
   endtask

   task automatic test_back_to_back();
`ifdef REGWR_ARB_STATS_EN
      checks++;
      if (ConflictCount !== 16'd4) begin
         errors++;
         $display("FAIL conflict_count: got %0d, expected 4", ConflictCount);
      end
      ConflictClear = 1'b1;
`endif
      for (int i = 0; i < 8; i++) begin
         Req0Valid = 1'b1;
         Req0Reg   = 5'(i + 1);
         Req0Data  = 32'h100 + 32'(i);
         push(5'(i + 1), 32'h100 + 32'(i));
         checks++;
         if (Req0Ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b, expected 1 (beat %0d)", Req0Ready, i);
         end
         step();
`ifdef REGWR_ARB_STATS_EN
         ConflictClear = 1'b0;
`endif
         if (i > 0) begin
            checks++;
            if (RegWrite !== 1'b1) begin
               errors++;
               $display("FAIL b2b_we: got %b, expected 1 (beat %0d)", RegWrite, i);
            end
         end
      end
      idle();
      step();
      checks++;
      if (RegWrite !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last: got %b, expected 1", RegWrite);
      end
      step();
      checks++;
      if (RegWrite !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got %b, expected 0", RegWrite);
      end
`ifdef REGWR_ARB_STATS_EN
      checks++;
      if (ConflictCount !== 16'd0) begin
         errors++;
         $display("FAIL b2b_conflict: got %0d, expected 0", ConflictCount);
      end
`endif
      check_drained("b2b");
   endtask

   task automatic test_reset_mid();
      Req0Valid = 1'b1; Req0Reg = 5'd20; Req0Data = 32'h20;
      Req1Valid = 1'b1; Req1Reg = 5'd21; Req1Data = 32'h21;
      step();
      idle();
      checks++;
      if (PendingMask !== 32'h0030_0000) begin
         errors++;
         $display("FAIL mid_full: got %h, expected 00300000", PendingMask);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (RegWrite !== 1'b0 || PendingMask !== 32'h0 || Req0Ready !== 1'b0 || Req1Ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got we %b mask %h rdy %b%b, expected 0 0 00",
                  RegWrite, PendingMask, Req0Ready, Req1Ready);
      end
      exp_q.delete();
      step();
      step();
      #2 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (RegWrite !== 1'b0 || PendingMask !== 32'h0) begin
            errors++;
            $display("FAIL post_reset_quiet: got we %b mask %h, expected 0 0", RegWrite, PendingMask);
         end
      end
      Req1Valid = 1'b1; Req1Reg = 5'd15; Req1Data = 32'hF00D;
      push(5'd15, 32'hF00D);
      step();
      idle();
      step();
      checks++;
      if (RegWrite !== 1'b1 || WriteRegister !== 5'd15 || WriteData !== 32'hF00D) begin
         errors++;
         $display("FAIL post_reset_write: got we %b reg %0d data %h, expected 1 15 0000f00d",
                  RegWrite, WriteRegister, WriteData);
      end
      step();
      check_drained("reset_mid");
   endtask

   initial begin
      for (int r = 0; r < 32; r++) model_rf[r] = 32'h0;
      test_reset();
      test_single();
      test_reg0();
      test_tie();
      test_oldest();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two writeback requesters: requester 0 (execute/ALU result) and requester 1 (memory load result). Each requester has a one-entry holding buffer with a valid/ready handshake. An oldest-first arbiter with a round-robin tie-break drains the buffers into a registered write stage that drives the register file's RegWrite/WriteRegister/WriteData inputs. A pending-write mask is exported so the decode stage can stall on registers that have outstanding writes.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register index width (2^ADDR_W registers)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- Req0Valid  in  1  requester 0 offers a write
- Req0Ready  out  1  requester 0 buffer can accept
- Req0Reg  in  ADDR_W  destination register, requester 0
- Req0Data  in  DATA_W  write data, requester 0
- Req1Valid, Req1Ready, Req1Reg, Req1Data: same as above, for requester 1
- RegWrite  out  1  register-file write enable (registered)
- WriteRegister  out  ADDR_W  register-file write index (registered)
- WriteData  out  DATA_W  register-file write data (registered)
- PendingMask  out  2^ADDR_W  bit r = 1 while a write to r is buffered or in the write stage

## Operation
- Transfer on requester i: ReqiValid && ReqiReady at a rising edge loads buffer i with {reg, data} and marks it full.
- ReqiReady = !reset_active && (buffer i empty || buffer i granted this cycle). This is combinational from state only and does not depend on ReqiValid.
- Writes to register 0 are accepted and immediately discarded:
  - the buffer stays empty;
  - no grant is made;
  - no PendingMask bit is set.
- Age tracking: one age bit records which full buffer was loaded first. It is set when a buffer is loaded while the other buffer is already full and not being drained.
- Arbitration, each cycle:
  - neither buffer full: no grant;
  - one buffer full: grant it;
  - both full: grant the older one;
  - both loaded on the same edge: grant the buffer named by the round-robin pointer.
  - The pointer flips to the non-granted requester after every tie-break.
- Grant effect at the next edge:
  - the granted buffer's {reg, data} loads the write stage with RegWrite = 1;
  - the buffer empties unless it is reloaded on that same edge.
- No grant: RegWrite = 0 at the next edge. WriteRegister and WriteData hold their previous values.
- Same destination held in both buffers: the older write is committed first, so the final register value comes from the younger request. Ordering across different acceptance times is the upstream's responsibility.
- PendingMask is the OR of:
  - the one-hot decode of each full buffer's register;
  - the write-stage register when RegWrite = 1.
  - Bit 0 is always 0.

## Timing
- Reset values:
  - buffers empty, age bit 0, pointer 0;
  - RegWrite 0, WriteRegister 0, WriteData 0, PendingMask 0;
  - Req0Ready and Req1Ready both 0 while reset = 0.
- Latency with no contention:
  - accepted at edge N;
  - granted in cycle N..N+1;
  - RegWrite high from edge N+1 to edge N+2;
  - the register file commits at edge N+2.
- Throughput: one write per cycle sustained. Under continuous contention each requester gets every other slot.
- A buffer can be drained and refilled on the same edge; Ready stays 1.
- Reset asserted mid-operation: all buffered and staged writes are dropped immediately (asynchronous). No RegWrite pulse occurs after release until a new transfer.
- Deassertion of reset is synchronized externally; the block uses reset only as an asynchronous clear.

## Configuration
- REGWR_ARB_STATS_EN defined:
  - adds output ConflictCount [15:0], a saturating counter of cycles in which both buffers are full (one requester waits);
  - adds input ConflictClear, a synchronous clear to 0;
  - ConflictCount resets to 0.
- REGWR_ARB_STATS_EN undefined: neither port nor the counter exists. All other behaviour is identical.

## Structure
- Shared package holds:
  - DATA_W/ADDR_W defaults;
  - the write-request struct typedef {reg, data};
  - the requester index constants REQ_EX = 0 and REQ_MEM = 1.
- One sub-module: regfile_wr_buffer. It is the one-entry holding buffer, instantiated twice, and provides full, reg, data, load, drain and the ready computation.
- Arbitration, age/pointer state, the write stage and the PendingMask decode stay in the top level.

## Test plan
- Single write: Req0 {reg 5, data 0xDEADBEEF} at edge N -> RegWrite = 1 with WriteRegister 5 and WriteData 0xDEADBEEF during N+1..N+2. PendingMask[5] = 1 from N until edge N+2, then 0.
- Register 0: Req1 {reg 0, data 0x1234} -> RegWrite stays 0, PendingMask stays 0, Req1Ready stays 1.
- Simultaneous accept: Req0 {3, 0xA} and Req1 {4, 0xB} on the same edge, pointer 0 -> reg 3 written first, then reg 4. A second tie then grants Req1 first.
- Oldest first: Req1 {7, 0x1} one cycle before Req0 {7, 0x2} while the write stage is busy -> reg 7 written 0x1 then 0x2. Final value 0x2.
- Back-to-back: Req0Valid held for 8 cycles with distinct data -> 8 consecutive RegWrite cycles, Req0Ready constantly 1. With REGWR_ARB_STATS_EN, ConflictCount stays 0.
- Reset mid-flight: both buffers full, reset drops to 0 -> RegWrite, PendingMask and Ready go 0 immediately. After release, no write occurs without new requests.
